// File: rtl/arbitro_rr_fifos_pkg.sv
// Shared widths, state encoding and reset constants for the round-robin FIFO pop arbiter.
package arbitro_rr_fifos_pkg;

  localparam int unsigned DATA_W_DEF = 10;
  localparam int unsigned N_FIFO     = 4;
  localparam int unsigned IDX_W      = 2;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_PAUSE  = 2'd3
  } arb_state_e;

  // Pointer parked on the last FIFO so FIFO_0 wins the first search after reset.
  localparam logic [IDX_W-1:0] RR_PTR_RST = IDX_W'(N_FIFO - 1);

endpackage

// File: rtl/arbitro_rr_fifos_selector_rr.sv
// Combinational round-robin selector: first requester after i_rr_ptr, searching upward mod N_FIFO.
module arbitro_rr_fifos_selector_rr
  import arbitro_rr_fifos_pkg::*;
(
  input  logic [N_FIFO-1:0] i_req,
  input  logic [IDX_W-1:0]  i_rr_ptr,
  output logic [N_FIFO-1:0] o_gnt,
  output logic [IDX_W-1:0]  o_gnt_idx,
  output logic              o_any
);

  logic [IDX_W-1:0] w_idx;

  // The pointer itself is searched last, so the previous winner only repeats when alone.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    w_idx     = '0;
    for (int unsigned i = 1; i <= N_FIFO; i++) begin
      w_idx = i_rr_ptr + IDX_W'(i);
      if (!o_any && i_req[w_idx]) begin
        o_any        = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_gnt_idx    = w_idx;
      end
    end
  end

endmodule

// File: rtl/arbitro_rr_fifos.sv
// Round-robin pop arbiter draining four FWFT input FIFOs into one downstream FIFO, one word per cycle.
module arbitro_rr_fifos
  import arbitro_rr_fifos_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              empty_FIFO_0,
  input  logic              empty_FIFO_1,
  input  logic              empty_FIFO_2,
  input  logic              empty_FIFO_3,
  input  logic [DATA_W-1:0] data_out_FIFO_0,
  input  logic [DATA_W-1:0] data_out_FIFO_1,
  input  logic [DATA_W-1:0] data_out_FIFO_2,
  input  logic [DATA_W-1:0] data_out_FIFO_3,
  input  logic              almost_full_out,
  output logic              pop_0,
  output logic              pop_1,
  output logic              pop_2,
  output logic              pop_3,
  output logic [DATA_W-1:0] data_out,
  output logic              push_out,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              idle
);

  arb_state_e        r_state;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [DATA_W-1:0] r_data_out;
  logic              r_push_out;
  logic [IDX_W-1:0]  r_grant_idx;
  logic              r_idle;

  logic [N_FIFO-1:0] w_req;
  logic [N_FIFO-1:0] w_gnt;
  logic [IDX_W-1:0]  w_gnt_idx;
  logic              w_any;
  logic              w_pop_en;
  logic              w_pop_any;
  logic [N_FIFO-1:0] w_pop;
  logic [DATA_W-1:0] w_head [N_FIFO];
  logic [DATA_W-1:0] w_data_sel;

  assign w_req = ~{empty_FIFO_3, empty_FIFO_2, empty_FIFO_1, empty_FIFO_0};

  assign w_head[0] = data_out_FIFO_0;
  assign w_head[1] = data_out_FIFO_1;
  assign w_head[2] = data_out_FIFO_2;
  assign w_head[3] = data_out_FIFO_3;

  arbitro_rr_fifos_selector_rr u_selector_rr (
    .i_req     (w_req),
    .i_rr_ptr  (r_rr_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  // Pops follow the live empty/almost-full flags; nothing pops in reset or the cycle after it.
  assign w_pop_en   = rst_l & (r_state != ST_RESET) & ~almost_full_out;
  assign w_pop      = w_gnt & {N_FIFO{w_pop_en}};
  assign w_pop_any  = w_any & w_pop_en;
  assign w_data_sel = w_head[w_gnt_idx];

  assign pop_0 = w_pop[0];
  assign pop_1 = w_pop[1];
  assign pop_2 = w_pop[2];
  assign pop_3 = w_pop[3];

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_state     <= ST_RESET;
      r_rr_ptr    <= RR_PTR_RST;
      r_data_out  <= '0;
      r_push_out  <= 1'b0;
      r_grant_idx <= '0;
      r_idle      <= 1'b1;
    end else begin
      case (r_state)
        ST_RESET: r_state <= ST_IDLE;
        ST_IDLE, ST_ACTIVE, ST_PAUSE: begin
          if (almost_full_out) begin
            r_state <= ST_PAUSE;
          end else if (w_any) begin
            r_state <= ST_ACTIVE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // A popped head word is pushed downstream on the following cycle.
      if (w_pop_any) begin
        r_data_out  <= w_data_sel;
        r_push_out  <= 1'b1;
        r_grant_idx <= w_gnt_idx;
        r_rr_ptr    <= w_gnt_idx;
      end else begin
        r_push_out  <= 1'b0;
      end

      // Idle goes high together with the first cycle that has no push in flight.
      r_idle <= ~(|w_req) & ~w_pop_any;
    end
  end

  assign data_out  = r_data_out;
  assign push_out  = r_push_out;
  assign grant_idx = r_grant_idx;
  assign idle      = r_idle;

endmodule
